router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Control FSM for the 1x3 router; sequences the byte register/parity datapath and the write side of the three output FIFOs.
- Decodes the header address and waits for the destination FIFO to drain if necessary.
- Drives the phase strobes the datapath uses to latch the header, payload, full-byte and parity.
- Handles FIFO-full stalls and per-port soft-reset (read timeout) aborts.

Parameters:
- INVALID_ADDR, 2'b11, header address value that is never accepted; the packet is ignored in DECODE_ADDRESS.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- pkt_valid  input  1  source is driving packet bytes
- data_in  input  2  header address field (data bits [1:0]), sampled in DECODE_ADDRESS
- fifo_full  input  1  full flag of the currently selected FIFO
- fifo_empty_0/1/2  input  1 each  empty flags of FIFO 0/1/2
- soft_reset_0/1/2  input  1 each  read-timeout aborts for FIFO 0/1/2
- parity_done  input  1  datapath has captured the parity byte
- low_pkt_valid  input  1  datapath saw pkt_valid fall while stalled
- busy  output  1  source must hold the current byte
- detect_add  output  1  header-capture phase
- lfd_state  output  1  load-first-data phase
- ld_state  output  1  load-data phase
- laf_state  output  1  load-after-full phase
- full_state  output  1  FIFO-full stall phase
- write_enb_reg  output  1  FIFO write enable
- rst_int_reg  output  1  clear internal parity in the datapath
- state_o  output  3  current state encoding (debug)

Behaviour:
- States and encodings:
  - DECODE_ADDRESS = 0
  - LOAD_FIRST_DATA = 1
  - LOAD_DATA = 2
  - FIFO_FULL_STATE = 3
  - LOAD_AFTER_FULL = 4
  - LOAD_PARITY = 5
  - CHECK_PARITY_ERROR = 6
  - WAIT_TILL_EMPTY = 7
- Single registered state. All outputs are Moore, decoded combinationally from the state register.
- Reset (rst=0 at posedge): state = DECODE_ADDRESS, addr_q = 0. Resulting outputs: detect_add=1, all other strobes 0, busy=0, state_o=0.
- addr_q latches data_in on the cycle DECODE_ADDRESS sees pkt_valid=1 with data_in != INVALID_ADDR. It holds until the next such capture. empty_sel and soft_sel are selected by addr_q (and by data_in during the capture cycle).
- Transitions, highest priority first:
  1. rst=0.
  2. soft_sel=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS.
  3. Per-state rules:
- DECODE_ADDRESS:
  - pkt_valid, addr valid, selected FIFO empty -> LOAD_FIRST_DATA.
  - pkt_valid, addr valid, FIFO not empty -> WAIT_TILL_EMPTY.
  - Otherwise stay. This includes data_in = INVALID_ADDR.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: empty_sel -> LOAD_FIRST_DATA; else stay.
- Output decode:
  - detect_add = DECODE_ADDRESS; lfd_state = LOAD_FIRST_DATA; ld_state = LOAD_DATA; laf_state = LOAD_AFTER_FULL; full_state = FIFO_FULL_STATE; rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Simultaneous events: soft reset beats every other condition; in LOAD_DATA, fifo_full beats !pkt_valid; in LOAD_AFTER_FULL, parity_done beats low_pkt_valid.
- No illegal states: all 8 encodings are used. Reset mid-packet returns to DECODE_ADDRESS without waiting.

Test Plan:
1. Reset, then header 0x04 (addr 0), fifo_empty_0=1, 3 payload bytes, then pkt_valid=0 -> states 0,1,2,2,2,5,6,0. busy=1 in states 1, 5, 6. write_enb_reg=1 for 4 cycles (3 payload + parity).
2. Header addr 2 with fifo_empty_2=0 for 5 cycles, then 1 -> WAIT_TILL_EMPTY for 5 cycles with busy=1, then LOAD_FIRST_DATA. Also header addr 3 -> stays in DECODE_ADDRESS; addr_q unchanged.
3. fifo_full=1 in the 2nd LOAD_DATA cycle for 3 cycles -> FIFO_FULL_STATE for 3 cycles (full_state=1, busy=1, write_enb_reg=0), then LOAD_AFTER_FULL, then LOAD_DATA because parity_done=0 and low_pkt_valid=0.
4. From LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; parity_done=0 with low_pkt_valid=1 -> LOAD_PARITY, then CHECK_PARITY_ERROR (rst_int_reg=1 for one cycle).
5. Packet to addr 1 in LOAD_DATA with soft_reset_1 pulsed -> DECODE_ADDRESS next cycle. soft_reset_0 pulsed at the same time as a stall on addr 1 -> no effect.
6. rst=0 asserted in FIFO_FULL_STATE -> next cycle state_o=0, detect_add=1, all other outputs 0.

Source files
------------

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - 1x3 router control FSM
//
// Purpose:
//   Sequences the router's byte register/parity datapath and the write side of
//   the three output FIFOs. It decodes the header address and waits for the
//   destination FIFO to drain when needed. It also handles FIFO-full stalls and
//   per-port soft-reset (read timeout) aborts.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   pkt_valid                     source is driving packet bytes
//   data_in[1:0]                  header address field, sampled in DECODE_ADDRESS
//   fifo_full                     full flag of the currently selected FIFO
//   fifo_empty_0/1/2              empty flags of the three FIFOs
//   soft_reset_0/1/2              read-timeout aborts of the three FIFOs
//   parity_done                   datapath has captured the parity byte
//   low_pkt_valid                 datapath saw pkt_valid fall while stalled
//   busy                          source must hold the current byte
//   detect_add/lfd_state/ld_state/laf_state/full_state
//                                 phase strobes for the datapath
//   write_enb_reg                 FIFO write enable
//   rst_int_reg                   clear internal parity in the datapath
//   state_o[2:0]                  current state encoding (debug)

module router_fsm #(
    parameter logic [1:0] INVALID_ADDR = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr_q;
    logic       w_capture;
    logic [1:0] w_sel_addr;
    logic       w_empty_sel;
    logic       w_soft_sel;

    // A header is accepted only in DECODE_ADDRESS with a valid address.
    assign w_capture = (r_state == DECODE_ADDRESS) && pkt_valid &&
                       (data_in != INVALID_ADDR);

    // During the capture cycle the address is not yet registered, so the
    // live header field steers the empty/soft-reset selection.
    assign w_sel_addr = w_capture ? data_in : r_addr_q;

    always_comb begin
        w_empty_sel = 1'b0;
        w_soft_sel  = 1'b0;
        case (w_sel_addr)
            2'd0: begin
                w_empty_sel = fifo_empty_0;
                w_soft_sel  = soft_reset_0;
            end
            2'd1: begin
                w_empty_sel = fifo_empty_1;
                w_soft_sel  = soft_reset_1;
            end
            2'd2: begin
                w_empty_sel = fifo_empty_2;
                w_soft_sel  = soft_reset_2;
            end
            default: begin
                w_empty_sel = 1'b0;
                w_soft_sel  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= DECODE_ADDRESS;
            r_addr_q <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr_q <= data_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_soft_sel && (r_state != DECODE_ADDRESS)) begin
            // A read-timeout abort on the active port drops the packet.
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_capture) begin
                        w_next = w_empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: w_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        w_next = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        w_next = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next = LOAD_PARITY;
                    end else begin
                        w_next = LOAD_DATA;
                    end
                end
                LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_empty_sel) begin
                        w_next = LOAD_FIRST_DATA;
                    end
                end
                default: w_next = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        full_state    = (r_state == FIFO_FULL_STATE);
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
        busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);
        state_o       = r_state;
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed self-checking bench for router_fsm

module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;
    int wen_cnt;
    int busy_cnt;

    router_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .busy         (busy),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg  (rst_int_reg),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    wire [7:0] outs = {busy, detect_add, lfd_state, ld_state,
                       laf_state, full_state, write_enb_reg, rst_int_reg};

    // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int} per state.
    function automatic logic [7:0] exp_outs(input logic [2:0] s);
        case (s)
            3'd0:    return 8'b0100_0000;
            3'd1:    return 8'b1010_0000;
            3'd2:    return 8'b0001_0010;
            3'd3:    return 8'b1000_0100;
            3'd4:    return 8'b1000_1010;
            3'd5:    return 8'b1000_0010;
            3'd6:    return 8'b1000_0001;
            default: return 8'b1000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare state and the full output vector.
    task automatic step(input string tag, input logic [2:0] exp_state);
        @(posedge clk);
        #1;
        check({tag, ".state"}, state_o, exp_state);
        check({tag, ".outs"}, outs, exp_outs(exp_state));
        if (write_enb_reg) wen_cnt++;
        if (busy) busy_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        wen_cnt = 0; busy_cnt = 0;

        // Reset state
        step("rst0", 3'd0);
        step("rst1", 3'd0);
        rst = 1'b1;

        // 1: packet to addr 0, three payload bytes
        wen_cnt = 0; busy_cnt = 0;
        pkt_valid = 1'b1; data_in = 2'd0;
        step("t1a", 3'd1);
        step("t1b", 3'd2);
        step("t1c", 3'd2);
        step("t1d", 3'd2);
        pkt_valid = 1'b0;
        step("t1e", 3'd5);
        step("t1f", 3'd6);
        step("t1g", 3'd0);
        check("t1.wen_cycles", wen_cnt, 4);
        check("t1.busy_cycles", busy_cnt, 3);

        // 2: addr 2 while FIFO 2 not empty
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step("t2w0", 3'd7);
        pkt_valid = 1'b0;
        for (int i = 1; i < 5; i++) step("t2w", 3'd7);
        fifo_empty_2 = 1'b1;
        step("t2lfd", 3'd1);
        step("t2ld", 3'd2);
        step("t2lp", 3'd5);
        step("t2cp", 3'd6);
        step("t2dec", 3'd0);
        // invalid header address is ignored
        pkt_valid = 1'b1; data_in = 2'd3;
        step("t2inv0", 3'd0);
        step("t2inv1", 3'd0);

        // 3: FIFO-full stall in 2nd LOAD_DATA cycle for 3 cycles
        data_in = 2'd0;
        step("t3lfd", 3'd1);
        step("t3ld1", 3'd2);
        step("t3ld2", 3'd2);
        fifo_full = 1'b1;
        step("t3ff1", 3'd3);
        step("t3ff2", 3'd3);
        step("t3ff3", 3'd3);
        fifo_full = 1'b0;
        step("t3laf", 3'd4);
        step("t3ld", 3'd2);
        pkt_valid = 1'b0;
        step("t3lp", 3'd5);
        step("t3cp", 3'd6);
        step("t3dec", 3'd0);

        // 4a: LOAD_AFTER_FULL with parity_done
        pkt_valid = 1'b1;
        step("t4alfd", 3'd1);
        step("t4ald", 3'd2);
        fifo_full = 1'b1;
        step("t4aff", 3'd3);
        fifo_full = 1'b0;
        step("t4alaf", 3'd4);
        parity_done = 1'b1; low_pkt_valid = 1'b1;
        step("t4adec", 3'd0);
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        // 4b: LOAD_AFTER_FULL with low_pkt_valid, then CHECK_PARITY_ERROR stall
        step("t4blfd", 3'd1);
        step("t4bld", 3'd2);
        fifo_full = 1'b1;
        step("t4bff", 3'd3);
        fifo_full = 1'b0;
        step("t4blaf", 3'd4);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step("t4blp", 3'd5);
        low_pkt_valid = 1'b0;
        step("t4bcp", 3'd6);
        fifo_full = 1'b1;
        step("t4bff2", 3'd3);
        fifo_full = 1'b0;
        step("t4blaf2", 3'd4);
        parity_done = 1'b1;
        step("t4bdec", 3'd0);
        parity_done = 1'b0;

        // 5: soft resets on addr 1
        pkt_valid = 1'b1; data_in = 2'd1;
        step("t5lfd", 3'd1);
        step("t5ld", 3'd2);
        soft_reset_1 = 1'b1; fifo_full = 1'b1;
        step("t5abort", 3'd0);
        fifo_full = 1'b0; pkt_valid = 1'b0;
        step("t5dec_sr", 3'd0);
        soft_reset_1 = 1'b0; pkt_valid = 1'b1;
        step("t5lfd2", 3'd1);
        step("t5ld2", 3'd2);
        fifo_full = 1'b1;
        step("t5ff", 3'd3);
        soft_reset_0 = 1'b1; soft_reset_2 = 1'b1;
        step("t5other_sr", 3'd3);
        soft_reset_0 = 1'b0; soft_reset_2 = 1'b0; fifo_full = 1'b0;
        step("t5laf", 3'd4);
        parity_done = 1'b1;
        step("t5dec", 3'd0);
        parity_done = 1'b0;

        // 6: fifo_full beats !pkt_valid, then reset mid-stall
        data_in = 2'd0;
        step("t6lfd", 3'd1);
        step("t6ld", 3'd2);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step("t6ff", 3'd3);
        rst = 1'b0;
        step("t6rst", 3'd0);
        rst = 1'b1; fifo_full = 1'b0;
        step("t6idle", 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
